// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Two-requester round-robin write arbiter feeding a sync FIFO,
//               with bounded bursts and full-flag stall.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid_i,
    input  logic              req1_valid_i,
    input  logic [DATA_W-1:0] req0_data_i,
    input  logic [DATA_W-1:0] req1_data_i,
    output logic              req0_ready_o,
    output logic              req1_ready_o,
    output logic              fifo_wr_en_o,
    output logic [DATA_W-1:0] fifo_data_o,
    input  logic              fifo_full_i,
    output logic [1:0]        grant_o
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_GNT0   = 2'd1;
    localparam logic [1:0] c_ST_GNT1   = 2'd2;
    localparam logic [3:0] c_BURST_MAX = 4'(BURST_MAX);
    localparam logic [3:0] c_LAST_BEAT = c_BURST_MAX - 4'd1;

    logic [1:0] r_state;
    logic       r_prio;
    logic [3:0] r_cnt;

    logic [1:0] w_next_state;
    logic       w_beat;
    logic       w_burst_end;
    logic       w_entry;

    always_comb begin
        w_beat = 1'b0;
        if (!fifo_full_i) begin
            if (r_state == c_ST_GNT0) w_beat = req0_valid_i;
            if (r_state == c_ST_GNT1) w_beat = req1_valid_i;
        end
    end

    assign w_burst_end = (r_cnt == c_LAST_BEAT);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (req0_valid_i && req1_valid_i)
                    w_next_state = r_prio ? c_ST_GNT1 : c_ST_GNT0;
                else if (req0_valid_i)
                    w_next_state = c_ST_GNT0;
                else if (req1_valid_i)
                    w_next_state = c_ST_GNT1;
            end
            c_ST_GNT0: begin
                if (!req0_valid_i)
                    w_next_state = req1_valid_i ? c_ST_GNT1 : c_ST_IDLE;
                else if (w_beat && w_burst_end && req1_valid_i)
                    w_next_state = c_ST_GNT1;
            end
            c_ST_GNT1: begin
                if (!req1_valid_i)
                    w_next_state = req0_valid_i ? c_ST_GNT0 : c_ST_IDLE;
                else if (w_beat && w_burst_end && req0_valid_i)
                    w_next_state = c_ST_GNT0;
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // A grant entry is any move into a GNT state from a different state.
    assign w_entry = (w_next_state != r_state) && (w_next_state != c_ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_prio  <= 1'b0;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            if (w_entry) begin
                r_cnt  <= 4'd0;
                r_prio <= (w_next_state == c_ST_GNT0);
            end else if (w_beat) begin
                // Burst limit reached with no competitor: keep the grant, restart count.
                r_cnt <= w_burst_end ? 4'd0 : r_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        grant_o      = 2'b00;
        fifo_data_o  = '0;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        fifo_wr_en_o = w_beat;
        case (r_state)
            c_ST_GNT0: begin
                grant_o      = 2'b01;
                fifo_data_o  = req0_data_i;
                req0_ready_o = w_beat;
            end
            c_ST_GNT1: begin
                grant_o      = 2'b10;
                fifo_data_o  = req1_data_i;
                req1_ready_o = w_beat;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
